jtframe_rom_arbiter: RTL
========================

// Module: jtframe_rom_arbiter
// PURPOSE
//  Shares the single SDRAM ROM read channel (sdram_req/ack/addr, data_read/data_rdy) among SLOTS game requesters
//  (CPU, char, scroll, obj, sound...). Each slot keeps a one-entry cache (last address + 32-bit word).
//  Requests that hit the cache are served with no SDRAM traffic. Misses are scheduled round-robin.
//  Sits between the game core and the board SDRAM controller; idles during ROM download.
// PARAMETERS
//  SLOTS   4    number of requesters (2..8)
//  AW      22   SDRAM word address width
//  DW      32   read data width
//  RR      1    1 = round-robin among misses; 0 = fixed priority, slot 0 highest
// PORTS
//  clk          in   1        single clock (SDRAM/ROM domain); every register on rising edge
//  rst_n        in   1        asynchronous reset, active low
//  downloading  in   1        ROM load in progress: no requests, flush caches
//  loop_rst     in   1        SDRAM controller init/reset: same effect as downloading
//  slot_cs      in   SLOTS    per-slot read request, level; held until slot_ok
//  slot_addr    in   SLOTS*AW per-slot word address; slot i = [i*AW +: AW]
//  slot_ok      out  SLOTS    slot_data valid for the current slot_addr
//  slot_data    out  SLOTS*DW per-slot cached word; slot i = [i*DW +: DW]
//  sdram_req    out  1        request to SDRAM controller
//  sdram_addr   out  AW       address for sdram_req; stable from req to data_rdy
//  sdram_ack    in   1        controller accepted the request
//  data_read    in   DW       SDRAM read data
//  data_rdy     in   1        data_read valid, one-cycle pulse
// BEHAVIOUR
//  Reset: sdram_req=0, sdram_addr=0, slot_ok=0, slot_data=0, all cache valid=0, state IDLE, rr pointer=0.
//  Hit_i = valid_i & (tag_i==slot_addr_i). slot_ok_i = slot_cs_i & hit_i (combinational).
//   slot_data_i is a register and changes only when the slot is filled.
//  Miss_i = slot_cs_i & ~hit_i & ~flush, with flush = downloading | loop_rst.
//  FSM (shared package enum):
//   IDLE: if any miss_i, grant g. RR=1: first miss at or after ptr, wrapping.
//         RR=0: lowest-index miss. Latch sdram_addr<=slot_addr_g, gnt<=g, sdram_req<=1 -> WAIT_ACK.
//   WAIT_ACK: on sdram_ack: sdram_req<=0 -> WAIT_RDY.
//             If data_rdy arrives in the same cycle, complete directly (fill, -> IDLE).
//   WAIT_RDY: on data_rdy: data_gnt<=data_read, tag_gnt<=sdram_addr, valid_gnt<=1,
//             ptr<=gnt+1 (mod SLOTS) -> IDLE.
//  Latency: a miss granted on IDLE edge t drives req at t+1. Slot_ok rises the cycle after data_rdy.
//   After a fill, the FSM spends one IDLE cycle before the next req.
//  Address change mid-fetch: the fill is still stored under the latched tag, so no hit results.
//   The slot re-requests from IDLE. No fetch is aborted for that reason.
//  cs dropped mid-fetch: the fetch completes and the cache is filled anyway.
//  Flush asserted in any state: sdram_req<=0, all valid<=0, state<=IDLE. Holds while flush=1.
//   A data_rdy arriving during flush is ignored.
//  At most one outstanding request. Width: ptr is $clog2(SLOTS) bits; wrap at SLOTS-1 -> 0 for non-power-of-2.
//  Spurious sdram_ack in IDLE/WAIT_RDY and data_rdy in IDLE/WAIT_ACK (without ack) are ignored.
// STRUCTURE
//  Package jtframe_rom_pkg: state enum {IDLE,WAIT_ACK,WAIT_RDY}, default AW/DW localparams.
//  Sub-module jtframe_rom_slot (one per slot, generate loop):
//   tag/data/valid registers, hit compare, fill and flush inputs.
//  Top level: arbiter FSM, RR pointer, SDRAM-side registers.
// TESTING
//  1 Reset, then slot0 cs, addr=0x00100; SDRAM model ack +2, rdy +4 with 0xDEADBEEF
//    -> one req with sdram_addr=0x00100; slot_ok0 set 1 cycle after rdy; slot_data0=0xDEADBEEF.
//  2 Same addr re-requested -> slot_ok0 set the same cycle, no sdram_req.
//  3 RR=1: all 4 slots miss together -> grants 0,1,2,3 in order.
//    Slot1 re-misses after its fill -> slot 2 is served before slot 1 again.
//  4 RR=0: slots 1 and 3 miss continuously -> slot 1 is always served first.
//    Slot 3 is served only when slot 1 hits.
//  5 Slot2 changes addr 0x200->0x204 while in WAIT_RDY -> fill tagged 0x200, slot_ok2 stays 0.
//    A second req is issued with addr 0x204.
//  6 downloading pulses during WAIT_ACK -> sdram_req drops the next cycle; the later data_rdy is ignored.
//    All slot_ok=0; the FSM re-requests after downloading clears.
//  Also: ack and rdy in the same cycle; rst_n asserted mid-fetch -> all outputs at reset values immediately.

Source files
------------

// File: rtl/jtframe_rom_pkg.sv
// ----------------------------------------------------------------------------
// jtframe_rom_pkg : shared types and defaults for the ROM read arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package jtframe_rom_pkg;
  localparam int DEF_AW = 22;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/jtframe_rom_arbiter_if.sv
// ----------------------------------------------------------------------------
// jtframe_rom_arbiter_if : game-side slot bus plus SDRAM read channel
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface jtframe_rom_arbiter_if
  import jtframe_rom_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
);
  logic [SLOTS-1:0]    slot_cs;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_data;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack;
  logic [DW-1:0]       data_read;
  logic                data_rdy;

  modport slave (
    input  slot_cs, slot_addr, sdram_ack, data_read, data_rdy,
    output slot_ok, slot_data, sdram_req, sdram_addr
  );

  modport master (
    output slot_cs, slot_addr, sdram_ack, data_read, data_rdy,
    input  slot_ok, slot_data, sdram_req, sdram_addr
  );
endinterface

`default_nettype wire

// File: rtl/jtframe_rom_slot.sv
// ----------------------------------------------------------------------------
// jtframe_rom_slot : one-entry tag/data cache for a single ROM requester
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtframe_rom_slot
  import jtframe_rom_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_cs,
  input  logic [AW-1:0] i_addr,
  input  logic          i_fill,
  input  logic [AW-1:0] i_fill_tag,
  input  logic [DW-1:0] i_fill_data,
  output logic          o_ok,
  output logic          o_miss,
  output logic [DW-1:0] o_data
);
  logic          r_valid;
  logic [AW-1:0] r_tag;
  logic [DW-1:0] r_data;
  logic          w_hit;

  assign w_hit  = r_valid && (r_tag == i_addr);
  assign o_ok   = i_cs & w_hit;
  assign o_miss = i_cs & ~w_hit & ~i_flush;
  assign o_data = r_data;

  // Flush only invalidates; the data word is kept until the next fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end
  end
endmodule

`default_nettype wire

// File: rtl/jtframe_rom_arbiter.sv
// ----------------------------------------------------------------------------
// jtframe_rom_arbiter : shares one SDRAM ROM read channel among cached slots
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtframe_rom_arbiter
  import jtframe_rom_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int RR    = 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_downloading,
  input  logic                  i_loop_rst,
  jtframe_rom_arbiter_if.slave  bus
);
  localparam int PW = $clog2(SLOTS);

  state_t           r_state, w_state_nxt;
  logic             r_req, w_req_nxt;
  logic [AW-1:0]    r_addr, w_addr_nxt;
  logic [PW-1:0]    r_gnt, w_gnt_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [PW-1:0]    w_sel, w_ptr_inc;
  logic             w_any, w_fill, w_flush;
  logic [SLOTS-1:0] w_miss, w_fill_vec, w_ok;
  logic [SLOTS*DW-1:0] w_data;
  int               w_idx;

  assign w_flush = i_downloading | i_loop_rst;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign w_fill_vec[gi] = w_fill && (r_gnt == PW'(gi));
      jtframe_rom_slot #(.AW(AW), .DW(DW)) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (w_flush),
        .i_cs        (bus.slot_cs[gi]),
        .i_addr      (bus.slot_addr[gi*AW +: AW]),
        .i_fill      (w_fill_vec[gi]),
        .i_fill_tag  (r_addr),
        .i_fill_data (bus.data_read),
        .o_ok        (w_ok[gi]),
        .o_miss      (w_miss[gi]),
        .o_data      (w_data[gi*DW +: DW])
      );
    end
  endgenerate

  assign bus.slot_ok    = w_ok;
  assign bus.slot_data  = w_data;
  assign bus.sdram_req  = r_req;
  assign bus.sdram_addr = r_addr;

  // Scan starts at the pointer (round-robin) or at slot 0 (fixed priority).
  always_comb begin : p_pick
    w_any = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int k = 0; k < SLOTS; k++) begin
      w_idx = ((RR != 0) ? int'(r_ptr) : 0) + k;
      if (w_idx >= SLOTS) w_idx = w_idx - SLOTS;
      if (!w_any && w_miss[w_idx[PW-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_idx[PW-1:0];
      end
    end
  end

  assign w_ptr_inc = (r_gnt == PW'(SLOTS-1)) ? '0 : r_gnt + 1'b1;

  always_comb begin : p_fsm
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_fill      = 1'b0;
    if (w_flush) begin
      w_state_nxt = IDLE;
      w_req_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            w_state_nxt = WAIT_ACK;
            w_req_nxt   = 1'b1;
            w_gnt_nxt   = w_sel;
            w_addr_nxt  = bus.slot_addr[int'(w_sel)*AW +: AW];
          end
        end
        WAIT_ACK: begin
          if (bus.sdram_ack) begin
            w_req_nxt = 1'b0;
            // Controller may return data in the very cycle it accepts.
            if (bus.data_rdy) begin
              w_fill      = 1'b1;
              w_ptr_nxt   = w_ptr_inc;
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = WAIT_RDY;
            end
          end
        end
        WAIT_RDY: begin
          if (bus.data_rdy) begin
            w_fill      = 1'b1;
            w_ptr_nxt   = w_ptr_inc;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end
endmodule

`default_nettype wire
